// File: rtl/card_arb_pkg.sv
// card_arb_pkg
//   Shared definitions for the card board arbiter slice:
//   - arbiter FSM state encodings (2-bit binary)
//   - last-winner encoding used for round-robin tie break
//   - card status codes stored in entry bits [5:4]
//   - default geometry (locations, address width, entry width, counter width)
package card_arb_pkg;

  localparam int NUM_LOCS_DEF = 16;
  localparam int LOC_W_DEF    = 4;
  localparam int DATA_W_DEF   = 6;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_A = 2'd1,
    ARB_GNT_B = 2'd2,
    ARB_LOCK  = 2'd3
  } arb_state_t;

  typedef enum logic {
    WIN_A = 1'b0,
    WIN_B = 1'b1
  } win_t;

  localparam logic [1:0] ST_SHOWN   = 2'b00;
  localparam logic [1:0] ST_HIDDEN  = 2'b01;
  localparam logic [1:0] ST_REMOVED = 2'b10;

endpackage

// File: rtl/card_board_ram.sv
// card_board_ram
//   NUM_LOCS x DATA_W register file holding the card board.
//   One write port, synchronous clear of every entry, registered read port.
//   Reads return the contents before any same-edge write or clear.
// Ports
//   Clk      in   system clock
//   Reset_n  in   synchronous active-low reset (clears entries and rd_data)
//   clr      in   clear all entries; overrides the write port
//   we       in   write enable
//   wr_loc   in   write address
//   wr_data  in   write data
//   rd_loc   in   read address
//   rd_data  out  mem[rd_loc], one cycle latency
module card_board_ram
  import card_arb_pkg::*;
#(
  parameter int NUM_LOCS = NUM_LOCS_DEF,
  parameter int LOC_W    = LOC_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clr,
  input  logic              we,
  input  logic [LOC_W-1:0]  wr_loc,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LOC_W-1:0]  rd_loc,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_LOCS];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LOCS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      // Non-blocking read samples the pre-edge contents (read-before-write).
      rd_data <= mem[rd_loc];
      if (clr) begin
        for (int i = 0; i < NUM_LOCS; i++) mem[i] <= '0;
      end else if (we) begin
        mem[wr_loc] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/card_board_arbiter.sv
// card_board_arbiter
//   Owns the card board memory and arbitrates writes between the gameplay
//   controller (A) and the cursor/highlight overlay (B) with a req/gnt
//   handshake. Ties alternate by last winner; A's lock stalls B entirely;
//   clr wipes the board and suppresses grants on that edge.
//   Optional build macro: CARD_ARB_STATS_EN enables the saturating
//   conflict counter; otherwise conflict_cnt is tied to zero.
// Ports
//   Clk           in   system clock
//   Reset_n       in   synchronous active-low reset
//   clr           in   clear every entry on the next edge
//   a_req/a_lock  in   A request (held until a_gnt) and exclusive lock
//   a_loc/a_data  in   A write address/data
//   a_gnt         out  one-cycle pulse: A write committed at previous edge
//   b_req         in   B request (held until b_gnt)
//   b_loc/b_data  in   B write address/data
//   b_gnt         out  one-cycle pulse: B write committed at previous edge
//   rd_loc        in   display read address
//   rd_data       out  mem[rd_loc], one cycle latency
//   conflict_cnt  out  saturating count of edges with a stalled request
module card_board_arbiter
  import card_arb_pkg::*;
#(
  parameter int NUM_LOCS = NUM_LOCS_DEF,
  parameter int LOC_W    = LOC_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clr,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic [LOC_W-1:0]  a_loc,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [LOC_W-1:0]  b_loc,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  input  logic [LOC_W-1:0]  rd_loc,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_t        state_q, state_d;
  win_t              last_win_q;
  logic              a_elig, b_elig;
  logic              win_a, win_b;
  logic              wr_en;
  logic [LOC_W-1:0]  wr_loc;
  logic [DATA_W-1:0] wr_data;

  // The ~x_gnt terms stop a requester still holding req during its grant
  // cycle from being written twice for the same request.
  assign a_elig = a_req & ~a_gnt;
  assign b_elig = b_req & ~b_gnt & ~a_lock;

  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (!clr) begin
      if (a_elig && b_elig) begin
        win_a = (last_win_q == WIN_B);
        win_b = (last_win_q == WIN_A);
      end else begin
        win_a = a_elig;
        win_b = b_elig;
      end
    end
  end

  assign wr_en   = win_a | win_b;
  assign wr_loc  = win_a ? a_loc  : b_loc;
  assign wr_data = win_a ? a_data : b_data;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ARB_IDLE;
      last_win_q <= WIN_B;
    end else begin
      state_q <= state_d;
      if (win_a)      last_win_q <= WIN_A;
      else if (win_b) last_win_q <= WIN_B;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = a_lock ? ARB_LOCK : ARB_IDLE;
    if (win_a)      state_d = ARB_GNT_A;
    else if (win_b) state_d = ARB_GNT_B;
  end

  // Outputs: grants are the registered GNT states, so each lasts one cycle.
  always_comb begin
    a_gnt = (state_q == ARB_GNT_A);
    b_gnt = (state_q == ARB_GNT_B);
  end

  card_board_ram #(
    .NUM_LOCS (NUM_LOCS),
    .LOC_W    (LOC_W),
    .DATA_W   (DATA_W)
  ) u_ram (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (clr),
    .we      (wr_en),
    .wr_loc  (wr_loc),
    .wr_data (wr_data),
    .rd_loc  (rd_loc),
    .rd_data (rd_data)
  );

`ifdef CARD_ARB_STATS_EN
  logic             stall;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A requester outside its grant cycle that did not win this edge is stalled
  // (lost a tie, locked out, or blocked by clr). One increment per edge.
  assign stall = (a_elig & ~win_a) | (b_req & ~b_gnt & ~win_b);

  always_ff @(posedge Clk) begin
    if (!Reset_n)   cnt_q <= '0;
    else if (stall) cnt_q <= sat_inc(cnt_q);
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_card_board_arbiter.sv
// tb_card_board_arbiter
//   Scoreboard bench: the stimulus process updates a behavioural board model
//   before every edge and queues the expected outputs; a monitor process pops
//   one entry per cycle after the edge and compares against the DUT.
module tb_card_board_arbiter;

  logic       Clk = 1'b0;
  logic       Reset_n, clr;
  logic       a_req, a_lock, b_req;
  logic [3:0] a_loc, b_loc, rd_loc;
  logic [5:0] a_data, b_data;
  logic       a_gnt, b_gnt;
  logic [5:0] rd_data;
  logic [7:0] conflict_cnt;

  always #5 Clk = ~Clk;

  card_board_arbiter dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .clr          (clr),
    .a_req        (a_req),
    .a_lock       (a_lock),
    .a_loc        (a_loc),
    .a_data       (a_data),
    .a_gnt        (a_gnt),
    .b_req        (b_req),
    .b_loc        (b_loc),
    .b_data       (b_data),
    .b_gnt        (b_gnt),
    .rd_loc       (rd_loc),
    .rd_data      (rd_data),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    logic       a_gnt;
    logic       b_gnt;
    logic [5:0] rd;
    logic [7:0] cnt;
    int         phase;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  // Behavioural model: board contents and who holds a grant right now.
  logic [5:0] m_mem [16];
  bit         m_ga, m_gb;
  bit         m_last_a;   // 1 when A won the most recent arbitration
  logic [5:0] m_rd;
  int         m_cnt;

  task automatic model_edge();
    exp_t e;
    bit   ea, eb, wa, wb, stalled;
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 6'h00;
      m_ga = 0; m_gb = 0; m_last_a = 0; m_rd = 6'h00; m_cnt = 0;
    end else begin
      ea = a_req && !m_ga;
      eb = b_req && !m_gb && !a_lock;
      wa = 0; wb = 0;
      if (!clr) begin
        if (ea && eb) begin
          if (m_last_a) wb = 1; else wa = 1;
        end else begin
          wa = ea; wb = eb;
        end
      end
      stalled = (ea && !wa) || (b_req && !m_gb && !wb);
      m_rd = m_mem[rd_loc];
      if (clr)     for (int i = 0; i < 16; i++) m_mem[i] = 6'h00;
      else if (wa) m_mem[a_loc] = a_data;
      else if (wb) m_mem[b_loc] = b_data;
      if (wa) m_last_a = 1;
      if (wb) m_last_a = 0;
      m_ga = wa; m_gb = wb;
`ifdef CARD_ARB_STATS_EN
      if (stalled && m_cnt < 255) m_cnt = m_cnt + 1;
`else
      m_cnt = 0;
`endif
    end
    e.a_gnt = m_ga; e.b_gnt = m_gb; e.rd = m_rd; e.cnt = m_cnt[7:0]; e.phase = phase;
    q.push_back(e);
  endtask

  // Inputs are set at a negedge; model the coming posedge, then move on.
  task automatic cycle();
    model_edge();
    @(negedge Clk);
  endtask

  task automatic chk(input string name, input int ph, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s phase %0d t=%0t: got %0h expected %0h", name, ph, $time, act, exp_v);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a_gnt",        e.phase, int'(a_gnt),        int'(e.a_gnt));
        chk("b_gnt",        e.phase, int'(b_gnt),        int'(e.b_gnt));
        chk("rd_data",      e.phase, int'(rd_data),      int'(e.rd));
        chk("conflict_cnt", e.phase, int'(conflict_cnt), int'(e.cnt));
      end
    end
  end

  task automatic idle_inputs();
    clr = 0; a_req = 0; a_lock = 0; b_req = 0;
    a_loc = 0; a_data = 0; b_loc = 0; b_data = 0; rd_loc = 0;
  endtask

  initial begin
    Reset_n = 0;
    idle_inputs();
    @(negedge Clk);

    // Reset, then read back every location as zero
    phase = 1;
    cycle(); cycle();
    Reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      rd_loc = i[3:0];
      cycle();
    end

    // Lone A write held one extra cycle, then read it back
    phase = 2;
    a_req = 1; a_loc = 4'd3; a_data = 6'h11;
    cycle(); cycle();
    a_req = 0; rd_loc = 4'd3;
    cycle(); cycle();

    // A and B held together from reset: alternate grants
    phase = 3;
    Reset_n = 0;
    cycle();
    Reset_n = 1;
    a_req = 1; a_loc = 4'd1; a_data = 6'h21;
    b_req = 1; b_loc = 4'd2; b_data = 6'h2A;
    repeat (6) cycle();
    a_req = 0; b_req = 0;
    cycle();

    // Lock: only A is granted; B goes on the edge after the lock drops
    phase = 4;
    a_lock = 1; a_req = 1; b_req = 1;
    a_loc = 4'd9; a_data = 6'h19; b_loc = 4'd10; b_data = 6'h2B;
    repeat (8) cycle();
    a_lock = 0;
    cycle(); cycle();
    a_req = 0; b_req = 0;
    cycle();

    // clr with a pending A request: no grant, then the write lands
    phase = 5;
    clr = 1; a_req = 1; a_loc = 4'd5; a_data = 6'h15; rd_loc = 4'd9;
    cycle();
    clr = 0; rd_loc = 4'd5;
    cycle(); cycle();
    a_req = 0;
    cycle(); cycle();

    // B write to the location being read: old data, then new
    phase = 6;
    b_req = 1; b_loc = 4'd7; b_data = 6'h3C; rd_loc = 4'd7;
    cycle();
    b_req = 0;
    cycle(); cycle();

    // Randomized traffic with clr, lock, reset, withdrawals and a long lock
    phase = 7;
    for (int n = 0; n < 2500; n++) begin
      bit long_lock;
      long_lock = (n >= 1000 && n < 1350);
      Reset_n = long_lock ? 1'b1 : ($urandom_range(0, 149) != 0);
      clr     = long_lock ? 1'b0 : ($urandom_range(0, 24) == 0);
      if (long_lock)                       a_lock = 1;
      else if ($urandom_range(0, 39) == 0) a_lock = ~a_lock;
      if (a_req && !m_ga) begin
        if ($urandom_range(0, 19) == 0) a_req = 0;
      end else if ($urandom_range(0, 2) != 0) begin
        a_req = 1; a_loc = 4'($urandom); a_data = 6'($urandom);
      end else begin
        a_req = 0;
      end
      if (long_lock) begin
        b_req = 1;
      end else if (b_req && !m_gb) begin
        if ($urandom_range(0, 19) == 0) b_req = 0;
      end else if ($urandom_range(0, 2) != 0) begin
        b_req = 1; b_loc = 4'($urandom); b_data = 6'($urandom);
      end else begin
        b_req = 0;
      end
      case ($urandom_range(0, 3))
        0:       rd_loc = a_loc;
        1:       rd_loc = b_loc;
        default: rd_loc = 4'($urandom);
      endcase
      cycle();
    end

    // Drain
    phase = 8;
    idle_inputs();
    Reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      rd_loc = i[3:0];
      cycle();
    end
    repeat (3) @(posedge Clk);
    #2;
    chk("scoreboard_drained", phase, q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
